// File: rtl/disp_ram_arbiter.sv
// Three-port arbiter and access sequencer for the 256x8 display RAM.
// Serialises row-scan, shift-engine and pattern-loader accesses into a 4-cycle ram_clk sequence.
module disp_ram_arbiter #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req0,
  input  logic       req1,
  input  logic       req2,
  input  logic       we0,
  input  logic       we1,
  input  logic       we2,
  input  logic [7:0] addr0,
  input  logic [7:0] addr1,
  input  logic [7:0] addr2,
  input  logic [7:0] din0,
  input  logic [7:0] din1,
  input  logic [7:0] din2,
  input  logic       lock0,
  input  logic       lock1,
  input  logic       lock2,
  output logic       ack0,
  output logic       ack1,
  output logic       ack2,
  output logic [7:0] rdata,
  output logic [1:0] gnt_id,
  output logic       busy,
  input  logic [7:0] ram_dout,
  output logic       ram_clk,
  output logic       ram_we,
  output logic [7:0] ram_addr,
  output logic [7:0] ram_din
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SETUP = 2'd1,
    S_PULSE = 2'd2,
    S_ACK   = 2'd3
  } state_t;

  localparam logic [2:0] AGE_LIM  = 3'(STARVE_LIMIT);
  localparam logic [1:0] GNT_NONE = 2'd3;

  state_t     state_q;
  logic [1:0] gnt_id_q;
  logic       ram_clk_q;
  logic       ram_we_q;
  logic [7:0] ram_addr_q;
  logic [7:0] ram_din_q;
  logic [7:0] rdata_q;
  logic [2:0] ack_q;
  logic       lock_vld_q;
  logic [1:0] lock_own_q;
  logic [2:0] age1_q;
  logic [2:0] age2_q;

  logic [3:0] req_v;
  logic [3:0] lock_v;
  logic       win_vld;
  logic [1:0] win_id;
  logic       sel_we;
  logic [7:0] sel_addr;
  logic [7:0] sel_din;

  // Index 3 is padding so a 2-bit port id can index these safely.
  assign req_v  = {1'b0, req2, req1, req0};
  assign lock_v = {1'b0, lock2, lock1, lock0};

  always_comb begin
    win_vld = 1'b0;
    win_id  = GNT_NONE;
    if (lock_vld_q) begin
      if (req_v[lock_own_q]) begin
        win_vld = 1'b1;
        win_id  = lock_own_q;
      end
    end else if (req1 && (age1_q >= AGE_LIM)) begin
      win_vld = 1'b1;
      win_id  = 2'd1;
    end else if (req2 && (age2_q >= AGE_LIM)) begin
      win_vld = 1'b1;
      win_id  = 2'd2;
    end else if (req0) begin
      win_vld = 1'b1;
      win_id  = 2'd0;
    end else if (req1) begin
      win_vld = 1'b1;
      win_id  = 2'd1;
    end else if (req2) begin
      win_vld = 1'b1;
      win_id  = 2'd2;
    end
  end

  always_comb begin
    sel_we   = 1'b0;
    sel_addr = 8'h00;
    sel_din  = 8'h00;
    unique case (win_id)
      2'd0:    begin sel_we = we0; sel_addr = addr0; sel_din = din0; end
      2'd1:    begin sel_we = we1; sel_addr = addr1; sel_din = din1; end
      2'd2:    begin sel_we = we2; sel_addr = addr2; sel_din = din2; end
      default: begin sel_we = 1'b0; sel_addr = 8'h00; sel_din = 8'h00; end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      gnt_id_q   <= GNT_NONE;
      ram_clk_q  <= 1'b0;
      ram_we_q   <= 1'b0;
      ram_addr_q <= 8'h00;
      ram_din_q  <= 8'h00;
      rdata_q    <= 8'h00;
      ack_q      <= 3'b000;
      lock_vld_q <= 1'b0;
      lock_own_q <= 2'd0;
      age1_q     <= 3'd0;
      age2_q     <= 3'd0;
    end else begin
      if (lock_vld_q && !lock_v[lock_own_q]) begin
        lock_vld_q <= 1'b0;
      end
      unique case (state_q)
        S_IDLE: begin
          if (win_vld) begin
            state_q    <= S_SETUP;
            gnt_id_q   <= win_id;
            ram_we_q   <= sel_we;
            ram_addr_q <= sel_addr;
            ram_din_q  <= sel_din;
            if (win_id == 2'd1) begin
              age1_q <= 3'd0;
            end else if (req1 && (age1_q != 3'd7)) begin
              age1_q <= age1_q + 3'd1;
            end
            if (win_id == 2'd2) begin
              age2_q <= 3'd0;
            end else if (req2 && (age2_q != 3'd7)) begin
              age2_q <= age2_q + 3'd1;
            end
          end
        end
        S_SETUP: begin
          state_q   <= S_PULSE;
          ram_clk_q <= 1'b1;
        end
        S_PULSE: begin
          state_q   <= S_ACK;
          ram_clk_q <= 1'b0;
          ram_we_q  <= 1'b0;
          rdata_q   <= ram_dout;
          ack_q     <= 3'b001 << gnt_id_q;
        end
        S_ACK: begin
          state_q  <= S_IDLE;
          ack_q    <= 3'b000;
          gnt_id_q <= GNT_NONE;
          // Taking the lock here overrides the release check above in the same cycle.
          if (lock_v[gnt_id_q]) begin
            lock_vld_q <= 1'b1;
            lock_own_q <= gnt_id_q;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign ack0     = ack_q[0];
  assign ack1     = ack_q[1];
  assign ack2     = ack_q[2];
  assign rdata    = rdata_q;
  assign gnt_id   = gnt_id_q;
  assign busy     = (state_q != S_IDLE);
  assign ram_clk  = ram_clk_q;
  assign ram_we   = ram_we_q;
  assign ram_addr = ram_addr_q;
  assign ram_din  = ram_din_q;

endmodule

// File: tb/tb_disp_ram_arbiter.sv
// Directed bench for disp_ram_arbiter: behavioural RAM on ram_clk, hand-computed expectations.
// Unwritten RAM locations read back as addr ^ 8'h79, so mem[0x23] = 0x5A.
module tb_disp_ram_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic       req0, req1, req2;
  logic       we0, we1, we2;
  logic [7:0] addr0, addr1, addr2;
  logic [7:0] din0, din1, din2;
  logic       lock0, lock1, lock2;
  logic       ack0, ack1, ack2;
  logic [7:0] rdata;
  logic [1:0] gnt_id;
  logic       busy;
  logic [7:0] ram_dout;
  logic       ram_clk;
  logic       ram_we;
  logic [7:0] ram_addr;
  logic [7:0] ram_din;

  always #5 clk = ~clk;

  disp_ram_arbiter dut (
    .clk(clk), .rst(rst),
    .req0(req0), .req1(req1), .req2(req2),
    .we0(we0), .we1(we1), .we2(we2),
    .addr0(addr0), .addr1(addr1), .addr2(addr2),
    .din0(din0), .din1(din1), .din2(din2),
    .lock0(lock0), .lock1(lock1), .lock2(lock2),
    .ack0(ack0), .ack1(ack1), .ack2(ack2),
    .rdata(rdata), .gnt_id(gnt_id), .busy(busy),
    .ram_dout(ram_dout), .ram_clk(ram_clk), .ram_we(ram_we),
    .ram_addr(ram_addr), .ram_din(ram_din)
  );

  function automatic logic [7:0] pat(input logic [7:0] a);
    return a ^ 8'h79;
  endfunction

  logic [7:0] wmem [256];
  bit         written [256];

  always @(posedge ram_clk) begin
    ram_dout <= written[ram_addr] ? wmem[ram_addr] : pat(ram_addr);
    if (ram_we) begin
      wmem[ram_addr]    <= ram_din;
      written[ram_addr] <= 1'b1;
    end
  end

  int clk_hi_cnt = 0;
  int we_hi_cnt  = 0;
  int ack1_cnt   = 0;
  always @(negedge clk) begin
    if (ram_clk) clk_hi_cnt++;
    if (ram_we)  we_hi_cnt++;
    if (ack1)    ack1_cnt++;
  end

  int         checks = 0;
  int         failures = 0;
  int         cyc = 0;
  int         multi_ack = 0;
  bit         hold0, hold2;
  int         log_port [$];
  int         log_cyc [$];
  logic [7:0] log_data [$];
  int         exp_port [10] = '{0, 0, 0, 0, 2, 0, 0, 0, 0, 2};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic clear_log();
    log_port.delete();
    log_cyc.delete();
    log_data.delete();
  endtask

  task automatic run_log(input int n);
    for (int i = 0; i < n; i++) begin
      tick();
      if ($countones({ack2, ack1, ack0}) > 1) multi_ack++;
      if (ack0 || ack1 || ack2) begin
        int p;
        p = ack0 ? 0 : (ack1 ? 1 : 2);
        log_port.push_back(p);
        log_cyc.push_back(cyc);
        log_data.push_back(rdata);
        if (ack0 && !hold0) req0 = 1'b0;
        if (ack1) req1 = 1'b0;
        if (ack2 && !hold2) req2 = 1'b0;
      end
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req0 = 1'b0; req1 = 1'b0; req2 = 1'b0;
    we0 = 1'b0; we1 = 1'b0; we2 = 1'b0;
    lock0 = 1'b0; lock1 = 1'b0; lock2 = 1'b0;
    hold0 = 1'b0; hold2 = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    int c0;
    int hi0;
    int we0s;
    int a1s;
    addr0 = 8'h00; addr1 = 8'h00; addr2 = 8'h00;
    din0 = 8'h00; din1 = 8'h00; din2 = 8'h00;
    do_reset();

    // reset values
    check("rst_gnt", 32'(gnt_id), 32'd3);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_ramclk", 32'(ram_clk), 32'd0);
    check("rst_ramwe", 32'(ram_we), 32'd0);
    check("rst_addr", 32'(ram_addr), 32'd0);
    check("rst_rdata", 32'(rdata), 32'd0);
    check("rst_acks", 32'({ack2, ack1, ack0}), 32'd0);

    // single read by port 2
    req2 = 1'b1; we2 = 1'b0; addr2 = 8'h23;
    hi0 = clk_hi_cnt; we0s = we_hi_cnt;
    tick();
    check("rd_gnt", 32'(gnt_id), 32'd2);
    check("rd_busy", 32'(busy), 32'd1);
    check("rd_addr", 32'(ram_addr), 32'h23);
    check("rd_setup_clk", 32'(ram_clk), 32'd0);
    tick();
    check("rd_pulse_clk", 32'(ram_clk), 32'd1);
    tick();
    check("rd_ack2", 32'(ack2), 32'd1);
    check("rd_data", 32'(rdata), 32'h5A);
    check("rd_ack_clk", 32'(ram_clk), 32'd0);
    req2 = 1'b0;
    tick();
    check("rd_ack_done", 32'(ack2), 32'd0);
    check("rd_idle_busy", 32'(busy), 32'd0);
    check("rd_idle_gnt", 32'(gnt_id), 32'd3);
    check("rd_clk_hi_cycles", 32'(clk_hi_cnt - hi0), 32'd1);
    check("rd_we_hi_cycles", 32'(we_hi_cnt - we0s), 32'd0);

    // fixed priority with simultaneous requests
    clear_log();
    addr0 = 8'h10; addr1 = 8'h11; addr2 = 8'h12;
    req0 = 1'b1; req1 = 1'b1; req2 = 1'b1;
    c0 = cyc;
    run_log(16);
    check("prio_count", 32'(log_port.size()), 32'd3);
    for (int i = 0; i < 3; i++) begin
      if (i < log_port.size()) begin
        check("prio_port", 32'(log_port[i]), 32'(i));
        check("prio_cycle", 32'(log_cyc[i] - c0), 32'(3 + 4 * i));
        check("prio_data", 32'(log_data[i]), 32'(pat(8'h10 + 8'(i))));
      end
    end

    // locked read-modify-write by port 1 with port 0 pending
    clear_log();
    req1 = 1'b1; we1 = 1'b0; addr1 = 8'h81; lock1 = 1'b1;
    tick();
    req0 = 1'b1; we0 = 1'b0; addr0 = 8'h40;
    tick();
    tick();
    check("rmw_rd_ack", 32'(ack1), 32'd1);
    check("rmw_rd_data", 32'(rdata), 32'(pat(8'h81)));
    we1 = 1'b1; addr1 = 8'h03; din1 = 8'hC3;
    tick();
    tick();
    check("rmw_lock_gnt", 32'(gnt_id), 32'd1);
    tick();
    check("rmw_wr_we", 32'(ram_we), 32'd1);
    check("rmw_wr_din", 32'(ram_din), 32'hC3);
    tick();
    check("rmw_wr_ack", 32'(ack1), 32'd1);
    req1 = 1'b0; lock1 = 1'b0; we1 = 1'b0;
    c0 = cyc;
    run_log(8);
    check("rmw_p0_count", 32'(log_port.size()), 32'd1);
    if (log_port.size() > 0) begin
      check("rmw_p0_port", 32'(log_port[0]), 32'd0);
      check("rmw_p0_cycle", 32'(log_cyc[0] - c0), 32'd4);
    end
    check("rmw_mem_written", 32'(written[3]), 32'd1);
    check("rmw_mem_data", 32'(wmem[3]), 32'hC3);

    // starvation: port 0 held, port 2 held
    do_reset();
    clear_log();
    hold0 = 1'b1; hold2 = 1'b1;
    req0 = 1'b1; addr0 = 8'h10;
    req2 = 1'b1; addr2 = 8'h12;
    run_log(44);
    check("starve_count", 32'(log_port.size() >= 10), 32'd1);
    for (int i = 0; i < 10; i++) begin
      if (i < log_port.size()) check("starve_port", 32'(log_port[i]), 32'(exp_port[i]));
    end
    if (log_data.size() > 4) check("starve_p2_data", 32'(log_data[4]), 32'(pat(8'h12)));

    // reset in PULSE of a locked write
    do_reset();
    req1 = 1'b1; we1 = 1'b0; addr1 = 8'h50; lock1 = 1'b1;
    tick();
    tick();
    tick();
    check("rstw_rd_ack", 32'(ack1), 32'd1);
    check("rstw_rd_data", 32'(rdata), 32'(pat(8'h50)));
    we1 = 1'b1; addr1 = 8'h05; din1 = 8'h77;
    req0 = 1'b1; we0 = 1'b0; addr0 = 8'h40;
    tick();
    tick();
    check("rstw_gnt", 32'(gnt_id), 32'd1);
    check("rstw_we", 32'(ram_we), 32'd1);
    tick();
    check("rstw_pulse", 32'(ram_clk), 32'd1);
    rst = 1'b1;
    a1s = ack1_cnt;
    tick();
    rst = 1'b0;
    check("rstw_we_cleared", 32'(ram_we), 32'd0);
    check("rstw_clk_cleared", 32'(ram_clk), 32'd0);
    check("rstw_gnt_none", 32'(gnt_id), 32'd3);
    check("rstw_busy", 32'(busy), 32'd0);
    check("rstw_addr", 32'(ram_addr), 32'd0);
    check("rstw_din", 32'(ram_din), 32'd0);
    check("rstw_rdata", 32'(rdata), 32'd0);
    check("rstw_no_ack", 32'({ack2, ack1, ack0}), 32'd0);
    tick();
    check("rstw_lock_cleared_gnt", 32'(gnt_id), 32'd0);
    tick();
    tick();
    check("rstw_p0_ack", 32'(ack0), 32'd1);
    check("rstw_p0_data", 32'(rdata), 32'(pat(8'h40)));
    check("rstw_inflight_no_ack1", 32'(ack1_cnt - a1s), 32'd0);
    req0 = 1'b0; req1 = 1'b0; lock1 = 1'b0;
    tick();
    check("one_hot_acks", 32'(multi_ack), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
